data_mem_controller: RTL and testbench

- Shares the DATA_MEM_NUM_CHANNELS external data-memory channels of the gpu top among NUM_CONSUMERS load/store requesters (per-core LSU lanes).
- Each channel runs an independent request FSM.
- Consumers are claimed round-robin; a consumer is never served by two channels at once.
- Sits between the cores' LSUs and the data_mem_* ports of the top level.

---
 rtl/data_mem_controller.sv | 164 ++++++++++++++++
 tb/tb_data_mem_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// Shares a small set of external data-memory channels among many LSU requesters.
// Each channel claims one consumer round-robin, runs the memory transaction, then relays completion.
module data_mem_controller #(
  parameter int NUM_CONSUMERS = 32,
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]             mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]             mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} chanState_e;

  chanState_e                 state_q   [NUM_CHANNELS];
  logic [CW-1:0]              owner_q   [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0]      addr_q    [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]      wdata_q   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    isRead_q;
  logic [NUM_CHANNELS-1:0]    rdValid_q;
  logic [NUM_CHANNELS-1:0]    wrValid_q;
  logic [NUM_CONSUMERS-1:0]   claimed_q;
  logic [NUM_CONSUMERS-1:0]   rdReady_q;
  logic [NUM_CONSUMERS-1:0]   wrReady_q;
  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] rdData_q;
  logic [CW-1:0]              rrPtr_q;

  logic [NUM_CONSUMERS-1:0]   reqMask;
  logic [NUM_CONSUMERS-1:0]   takenMask;
  logic [NUM_CHANNELS-1:0]    pickValid_d;
  logic [CW-1:0]              pickIdx_d [NUM_CHANNELS];
  logic [CW-1:0]              rrPtr_d;
  int                         scanIdx;

  assign reqMask = consumer_read_valid | consumer_write_valid;

  // Idle channels pick in ascending order; each excludes consumers already taken this cycle.
  always_comb begin
    takenMask = claimed_q;
    rrPtr_d   = rrPtr_q;
    scanIdx   = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pickValid_d[c] = 1'b0;
      pickIdx_d[c]   = '0;
      if (state_q[c] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          scanIdx = (int'(rrPtr_q) + k) % NUM_CONSUMERS;
          if (!pickValid_d[c] && reqMask[scanIdx] && !takenMask[scanIdx]) begin
            pickValid_d[c]     = 1'b1;
            pickIdx_d[c]       = CW'(scanIdx);
            takenMask[scanIdx] = 1'b1;
            rrPtr_d            = CW'((scanIdx + 1) % NUM_CONSUMERS);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      isRead_q  <= '0;
      rdValid_q <= '0;
      wrValid_q <= '0;
      claimed_q <= '0;
      rdReady_q <= '0;
      wrReady_q <= '0;
      rdData_q  <= '0;
      rrPtr_q   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
      end
    end else begin
      rrPtr_q <= rrPtr_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state_q[c])
          IDLE: begin
            if (pickValid_d[c]) begin
              owner_q[c]              <= pickIdx_d[c];
              claimed_q[pickIdx_d[c]] <= 1'b1;
              if (consumer_read_valid[pickIdx_d[c]]) begin
                isRead_q[c]  <= 1'b1;
                rdValid_q[c] <= 1'b1;
                addr_q[c]    <= consumer_read_address[int'(pickIdx_d[c])*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q[c]   <= '0;
                state_q[c]   <= READ_WAIT;
              end else begin
                isRead_q[c]  <= 1'b0;
                wrValid_q[c] <= 1'b1;
                addr_q[c]    <= consumer_write_address[int'(pickIdx_d[c])*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q[c]   <= consumer_write_data[int'(pickIdx_d[c])*DATA_WIDTH +: DATA_WIDTH];
                state_q[c]   <= WRITE_WAIT;
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[c]) begin
              rdData_q[int'(owner_q[c])*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data[c*DATA_WIDTH +: DATA_WIDTH];
              rdReady_q[owner_q[c]] <= 1'b1;
              rdValid_q[c]          <= 1'b0;
              addr_q[c]             <= '0;
              state_q[c]            <= RELAY;
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              wrReady_q[owner_q[c]] <= 1'b1;
              wrValid_q[c]          <= 1'b0;
              addr_q[c]             <= '0;
              wdata_q[c]            <= '0;
              state_q[c]            <= RELAY;
            end
          end
          RELAY: begin
            // Release only once the consumer drops the valid of the operation just completed.
            if (isRead_q[c] ? !consumer_read_valid[owner_q[c]] : !consumer_write_valid[owner_q[c]]) begin
              rdReady_q[owner_q[c]] <= 1'b0;
              wrReady_q[owner_q[c]] <= 1'b0;
              claimed_q[owner_q[c]] <= 1'b0;
              isRead_q[c]           <= 1'b0;
              state_q[c]            <= IDLE;
            end
          end
          default: state_q[c] <= IDLE;
        endcase
      end
    end
  end

  assign consumer_read_ready  = rdReady_q;
  assign consumer_read_data   = rdData_q;
  assign consumer_write_ready = wrReady_q;
  assign mem_read_valid       = rdValid_q;
  assign mem_write_valid      = wrValid_q;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_address[c*ADDR_WIDTH +: ADDR_WIDTH]  = rdValid_q[c] ? addr_q[c] : '0;
      mem_write_address[c*ADDR_WIDTH +: ADDR_WIDTH] = wrValid_q[c] ? addr_q[c] : '0;
      mem_write_data[c*DATA_WIDTH +: DATA_WIDTH]    = wrValid_q[c] ? wdata_q[c] : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed self-checking bench: 4 consumers share 2 channels behind a latency-configurable memory model.
`timescale 1ns/1ps
module tb_data_mem_controller;

  localparam int NC  = 4;
  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int DW  = 32;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     consumer_read_valid;
  logic [NC*AW-1:0]  consumer_read_address;
  logic [NC-1:0]     consumer_read_ready;
  logic [NC*DW-1:0]  consumer_read_data;
  logic [NC-1:0]     consumer_write_valid;
  logic [NC*AW-1:0]  consumer_write_address;
  logic [NC*DW-1:0]  consumer_write_data;
  logic [NC-1:0]     consumer_write_ready;
  logic [NCH-1:0]    mem_read_valid;
  logic [NCH*AW-1:0] mem_read_address;
  logic [NCH-1:0]    mem_read_ready;
  logic [NCH*DW-1:0] mem_read_data;
  logic [NCH-1:0]    mem_write_valid;
  logic [NCH*AW-1:0] mem_write_address;
  logic [NCH*DW-1:0] mem_write_data;
  logic [NCH-1:0]    mem_write_ready;

  int          readWait;
  int          writeWait;
  int          rdCnt [NCH];
  int          wrCnt [NCH];
  logic [AW-1:0] lastWrAddr;
  logic [DW-1:0] lastWrData;
  int          checkCount;
  int          errorCount;

  data_mem_controller #(
    .NUM_CONSUMERS(NC),
    .NUM_CHANNELS (NCH),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .consumer_write_valid  (consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data   (consumer_write_data),
    .consumer_write_ready  (consumer_write_ready),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data),
    .mem_write_valid       (mem_write_valid),
    .mem_write_address     (mem_write_address),
    .mem_write_data        (mem_write_data),
    .mem_write_ready       (mem_write_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memValue(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {24'h0, a};
  endfunction

  function automatic logic [AW-1:0] addrOf(input int i);
    return 8'h40 + AW'(i);
  endfunction

  // Memory answers once a channel's valid has been waiting readWait/writeWait cycles.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      mem_read_ready[c]        = mem_read_valid[c] && (rdCnt[c] >= readWait);
      mem_read_data[c*DW +: DW] = memValue(mem_read_address[c*AW +: AW]);
      mem_write_ready[c]       = mem_write_valid[c] && (wrCnt[c] >= writeWait);
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      rdCnt[c] <= (mem_read_valid[c] && !mem_read_ready[c]) ? rdCnt[c] + 1 : 0;
      wrCnt[c] <= (mem_write_valid[c] && !mem_write_ready[c]) ? wrCnt[c] + 1 : 0;
      if (mem_write_valid[c] && mem_write_ready[c]) begin
        lastWrAddr <= mem_write_address[c*AW +: AW];
        lastWrData <= mem_write_data[c*DW +: DW];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] rdMask, input logic [NC-1:0] wrMask);
    consumer_read_valid  = rdMask;
    consumer_write_valid = wrMask;
  endtask

  // Raise the given read requests and expect channel 0 to serve exp0 and channel 1 exp1 (-1 = idle).
  task automatic serveReads(input logic [NC-1:0] mask, input int exp0, input int exp1);
    logic [NC-1:0]  served;
    logic [NCH-1:0] expValid;
    served       = '0;
    served[exp0] = 1'b1;
    expValid     = 2'b01;
    if (exp1 >= 0) begin
      served[exp1] = 1'b1;
      expValid     = 2'b11;
    end
    applyStimulus(mask, '0);
    tick();
    checkOutput("rd_claim_valid", {62'h0, mem_read_valid}, {62'h0, expValid});
    checkOutput("rd_ch0_addr", {56'h0, mem_read_address[7:0]}, {56'h0, addrOf(exp0)});
    if (exp1 >= 0) checkOutput("rd_ch1_addr", {56'h0, mem_read_address[15:8]}, {56'h0, addrOf(exp1)});
    tick();
    checkOutput("rd_ready", {60'h0, consumer_read_ready}, {60'h0, served});
    checkOutput("rd_data_ch0", {32'h0, consumer_read_data[exp0*DW +: DW]}, {32'h0, memValue(addrOf(exp0))});
    if (exp1 >= 0) checkOutput("rd_data_ch1", {32'h0, consumer_read_data[exp1*DW +: DW]}, {32'h0, memValue(addrOf(exp1))});
    applyStimulus(mask & ~served, '0);
    tick();
    checkOutput("rd_release", {60'h0, consumer_read_ready}, 64'h0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    readWait   = 0;
    writeWait  = 0;
    reset      = 1'b1;
    consumer_read_address  = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    applyStimulus('0, '0);
    tick();
    tick();
    checkOutput("reset_mem_rd_valid", {62'h0, mem_read_valid}, 64'h0);
    checkOutput("reset_mem_wr_valid", {62'h0, mem_write_valid}, 64'h0);
    checkOutput("reset_rd_ready", {60'h0, consumer_read_ready}, 64'h0);
    checkOutput("reset_wr_ready", {60'h0, consumer_write_ready}, 64'h0);
    checkOutput("reset_rd_data", consumer_read_data[63:0], 64'h0);
    checkOutput("reset_mem_addr", {48'h0, mem_read_address, mem_write_address}, 64'h0);
    reset = 1'b0;
    tick();
    checkOutput("idle_no_request", {60'h0, mem_read_valid, mem_write_valid}, 64'h0);

    // Single read, zero-wait memory
    consumer_read_address[31:24] = 8'h10;
    applyStimulus(4'b1000, '0);
    tick();
    checkOutput("sr_mem_valid", {62'h0, mem_read_valid}, 64'h1);
    checkOutput("sr_mem_addr", {56'h0, mem_read_address[7:0]}, 64'h10);
    checkOutput("sr_ready_early", {60'h0, consumer_read_ready}, 64'h0);
    tick();
    checkOutput("sr_ready", {60'h0, consumer_read_ready}, 64'h8);
    checkOutput("sr_data", {32'h0, consumer_read_data[127:96]}, 64'hDEADBEEF);
    checkOutput("sr_mem_valid_drop", {62'h0, mem_read_valid}, 64'h0);
    tick();
    checkOutput("sr_ready_hold", {60'h0, consumer_read_ready}, 64'h8);
    applyStimulus('0, '0);
    tick();
    checkOutput("sr_ready_clear", {60'h0, consumer_read_ready}, 64'h0);

    // Single write, memory accepts on the third valid cycle
    writeWait = 2;
    consumer_write_address[7:0] = 8'h20;
    consumer_write_data[31:0]   = 32'h55;
    applyStimulus('0, 4'b0001);
    tick();
    checkOutput("sw_valid_c1", {62'h0, mem_write_valid}, 64'h1);
    checkOutput("sw_addr", {56'h0, mem_write_address[7:0]}, 64'h20);
    checkOutput("sw_data", {32'h0, mem_write_data[31:0]}, 64'h55);
    tick();
    checkOutput("sw_valid_c2", {62'h0, mem_write_valid}, 64'h1);
    tick();
    checkOutput("sw_valid_c3", {62'h0, mem_write_valid}, 64'h1);
    checkOutput("sw_ready_early", {60'h0, consumer_write_ready}, 64'h0);
    tick();
    checkOutput("sw_ready", {60'h0, consumer_write_ready}, 64'h1);
    checkOutput("sw_valid_drop", {62'h0, mem_write_valid}, 64'h0);
    checkOutput("sw_mem_addr", {56'h0, lastWrAddr}, 64'h20);
    checkOutput("sw_mem_data", {32'h0, lastWrData}, 64'h55);
    applyStimulus('0, '0);
    tick();
    checkOutput("sw_ready_clear", {60'h0, consumer_write_ready}, 64'h0);
    writeWait = 0;

    // Oversubscription from a fresh round-robin pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NC; i++) consumer_read_address[i*AW +: AW] = addrOf(i);
    serveReads(4'b1111, 0, 1);
    serveReads(4'b1100, 2, 3);

    // Round-robin wrap: pointer is 0, consumer 2 alone moves it to 3
    serveReads(4'b0100, 2, -1);
    serveReads(4'b1001, 3, 0);
    serveReads(4'b0101, 2, 0);

    // Read and write from the same consumer: read first, write after release
    consumer_read_address[15:8]  = 8'h50;
    consumer_write_address[15:8] = 8'h60;
    consumer_write_data[63:32]   = 32'h1234;
    applyStimulus(4'b0010, 4'b0010);
    tick();
    checkOutput("rw_read_first", {60'h0, mem_read_valid, mem_write_valid}, 64'h4);
    checkOutput("rw_read_addr", {56'h0, mem_read_address[7:0]}, 64'h50);
    tick();
    checkOutput("rw_rd_ready", {60'h0, consumer_read_ready}, 64'h2);
    checkOutput("rw_rd_data", {32'h0, consumer_read_data[63:32]}, 64'hC0DE0050);
    applyStimulus('0, 4'b0010);
    tick();
    checkOutput("rw_release_no_claim", {60'h0, consumer_read_ready, mem_write_valid}, 64'h0);
    tick();
    checkOutput("rw_write_valid", {62'h0, mem_write_valid}, 64'h1);
    checkOutput("rw_write_addr", {56'h0, mem_write_address[7:0]}, 64'h60);
    checkOutput("rw_write_data", {32'h0, mem_write_data[31:0]}, 64'h1234);
    tick();
    checkOutput("rw_wr_ready", {60'h0, consumer_write_ready}, 64'h2);
    checkOutput("rw_mem_data", {32'h0, lastWrData}, 64'h1234);
    applyStimulus('0, '0);
    tick();
    checkOutput("rw_wr_clear", {60'h0, consumer_write_ready}, 64'h0);

    // Reset while a read is outstanding, then the same request is served afresh
    readWait = 5;
    consumer_read_address[23:16] = 8'h44;
    applyStimulus(4'b0100, '0);
    tick();
    checkOutput("rst_rd_valid", {62'h0, mem_read_valid}, 64'h1);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_abort_valid", {60'h0, mem_read_valid, mem_write_valid}, 64'h0);
    checkOutput("rst_abort_ready", {60'h0, consumer_read_ready}, 64'h0);
    readWait = 0;
    reset    = 1'b0;
    tick();
    checkOutput("rst_new_valid", {62'h0, mem_read_valid}, 64'h1);
    checkOutput("rst_new_addr", {56'h0, mem_read_address[7:0]}, 64'h44);
    tick();
    checkOutput("rst_new_ready", {60'h0, consumer_read_ready}, 64'h4);
    checkOutput("rst_new_data", {32'h0, consumer_read_data[95:64]}, 64'hC0DE0044);
    applyStimulus('0, '0);
    tick();
    checkOutput("rst_new_clear", {60'h0, consumer_read_ready}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
